// File: rtl/ahb_sram_pkg.sv
// Shared types and helpers for the AHB-Lite SRAM slave: bus encodings,
// FSM state encoding, response codes and the byte-lane decode function.
package ahb_sram_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3,
    HSIZE_4W    = 3'd4,
    HSIZE_8W    = 3'd5,
    HSIZE_16W   = 3'd6,
    HSIZE_32W   = 3'd7
  } hsize_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_WR      = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_ERR1    = 3'd5,
    ST_ERR2    = 3'd6
  } sram_state_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Widest supported bus is 64 bits, so byte enables are computed over 8 lanes
  // and narrower buses take the low lanes.
  localparam int MAX_LANES = 8;

  // Little-endian byte enables: lanes addr_lo .. addr_lo + 2^hsize - 1.
  function automatic logic [MAX_LANES-1:0] calc_be(input logic [2:0] addr_lo,
                                                   input hsize_e     hsize);
    logic [MAX_LANES-1:0] be;
    int lo;
    int n;
    be = '0;
    lo = int'(addr_lo);
    n  = 1 << int'(hsize);
    for (int i = 0; i < MAX_LANES; i++) begin
      be[i] = (i >= lo) && (i < lo + n);
    end
    return be;
  endfunction

endpackage

// File: rtl/ahb_sram_addr_chk.sv
// Address-phase decode for the SRAM slave: flags out-of-range, oversize and
// misaligned transfers, and produces byte enables and the SRAM word address.
module ahb_sram_addr_chk
  import ahb_sram_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic [ADDR_WIDTH-1:0]        haddr,
  input  logic [2:0]                   hsize,
  output logic                         err,
  output logic [DATA_WIDTH/8-1:0]      be,
  output logic [$clog2(MEM_DEPTH)-1:0] word_addr
);

  localparam int LANES     = DATA_WIDTH / 8;
  localparam int LANE_BITS = $clog2(LANES);
  localparam int WORD_BITS = $clog2(MEM_DEPTH);
  localparam longint unsigned SPAN = longint'(MEM_DEPTH) * longint'(LANES);

  logic [2:0] addr_lo;
  logic [7:0] size_mask;
  logic       err_range;
  logic       err_size;
  logic       err_align;

  // Combinational legality check and lane/word decode of the current address phase.
  always_comb begin
    // NOTE: every output gets a value on every path through always_comb, so no latch is inferred.
    addr_lo   = 3'(haddr[LANE_BITS-1:0]);
    size_mask = (8'd1 << hsize) - 8'd1;
    err_range = 64'(haddr) >= SPAN;
    err_size  = hsize > 3'(LANE_BITS);
    err_align = |({5'b0, addr_lo} & size_mask);
    err       = err_range | err_size | err_align;
    be        = LANES'(calc_be(addr_lo, hsize_e'(hsize)));
    word_addr = haddr[LANE_BITS +: WORD_BITS];
  end

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite slave fronting a single-port synchronous SRAM macro.
// Configurable width/depth/wait states, byte-lane writes, two-cycle ERROR on
// illegal transfers. Define AHB_SRAM_PARITY_EN to add per-byte even parity
// ports and convert read parity mismatches into an ERROR response.
module ahb_lite_sram_slave
  import ahb_sram_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                         hclk,
  input  logic                         hresetn,
  input  logic                         hsel,
  input  logic [ADDR_WIDTH-1:0]        haddr,
  input  logic [1:0]                   htrans,
  input  logic [2:0]                   hsize,
  input  logic [2:0]                   hburst,
  input  logic                         hwrite,
  input  logic [DATA_WIDTH-1:0]        hwdata,
  input  logic                         hready,
  output logic                         hreadyout,
  output logic                         hresp,
  output logic [DATA_WIDTH-1:0]        hrdata,
  output logic                         sram_cs,
  output logic                         sram_we,
  output logic [DATA_WIDTH/8-1:0]      sram_be,
  output logic [$clog2(MEM_DEPTH)-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0]        sram_wdata,
  input  logic [DATA_WIDTH-1:0]        sram_rdata
`ifdef AHB_SRAM_PARITY_EN
  ,
  output logic [DATA_WIDTH/8-1:0]      sram_wpar,
  input  logic [DATA_WIDTH/8-1:0]      sram_rpar
`endif
);

  localparam int LANES     = DATA_WIDTH / 8;
  localparam int WORD_BITS = $clog2(MEM_DEPTH);
  localparam logic [1:0] WAIT_LOAD = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

  sram_state_e          state_q, state_d, start_state;
  logic [1:0]           wait_cnt_q;
  logic [WORD_BITS-1:0] addr_q;
  logic [LANES-1:0]     be_q;
  logic                 write_q;
  logic [DATA_WIDTH-1:0] hrdata_q;

  logic                 chk_err;
  logic [LANES-1:0]     chk_be;
  logic [WORD_BITS-1:0] chk_addr;
  logic                 addr_valid;
  logic                 ready_state;
  logic                 accept;
  logic                 par_err;

  // hburst is carried on the bus for debug visibility only.
  logic unused_hburst;
  assign unused_hburst = ^hburst;

  ahb_sram_addr_chk #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_addr_chk (
    .haddr     (haddr),
    .hsize     (hsize),
    .err       (chk_err),
    .be        (chk_be),
    .word_addr (chk_addr)
  );

  assign addr_valid = hsel && hready &&
                      (htrans_e'(htrans) == HTRANS_NONSEQ || htrans_e'(htrans) == HTRANS_SEQ);

  // Acceptance is only possible while this slave drives hreadyout high.
  always_comb begin
    ready_state = 1'b0;
    case (state_q)
      ST_IDLE, ST_WR, ST_ERR2: ready_state = 1'b1;
      ST_RD_DATA:              ready_state = !par_err;
      default:                 ready_state = 1'b0;
    endcase
  end

  assign accept = addr_valid && ready_state;

  // First data-phase state for a newly accepted transfer.
  always_comb begin
    if (chk_err)               start_state = ST_ERR1;
    else if (WAIT_STATES > 0)  start_state = ST_WAIT;
    else if (hwrite)           start_state = ST_WR;
    else                       start_state = ST_RD_REQ;
  end

  // FSM state register.
  always_ff @(posedge hclk or negedge hresetn) begin
    // NOTE: non-blocking (<=) in clocked blocks so every flop samples pre-edge values.
    if (!hresetn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_WR, ST_ERR2: state_d = accept ? start_state : ST_IDLE;
      ST_RD_DATA:              state_d = par_err ? ST_ERR2 : (accept ? start_state : ST_IDLE);
      ST_WAIT:                 if (wait_cnt_q == 2'd0) state_d = write_q ? ST_WR : ST_RD_REQ;
      ST_RD_REQ:               state_d = ST_RD_DATA;
      ST_ERR1:                 state_d = ST_ERR2;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // Address-phase capture, wait-state countdown and read-data holding register.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      addr_q     <= '0;
      be_q       <= '0;
      write_q    <= 1'b0;
      wait_cnt_q <= 2'd0;
      hrdata_q   <= '0;
    end else begin
      if (accept) begin
        addr_q     <= chk_addr;
        be_q       <= chk_be;
        write_q    <= hwrite;
        wait_cnt_q <= WAIT_LOAD;
      end else if (state_q == ST_WAIT && wait_cnt_q != 2'd0) begin
        wait_cnt_q <= wait_cnt_q - 2'd1;
      end
      if (state_q == ST_RD_DATA) hrdata_q <= sram_rdata;
    end
  end

  // FSM outputs: bus handshake and SRAM strobes per state.
  always_comb begin
    hreadyout  = 1'b1;
    hresp      = HRESP_OKAY;
    hrdata     = hrdata_q;
    sram_cs    = 1'b0;
    sram_we    = 1'b0;
    sram_be    = '0;
    sram_addr  = addr_q;
    sram_wdata = '0;
    case (state_q)
      ST_WAIT: hreadyout = 1'b0;
      ST_WR: begin
        sram_cs    = 1'b1;
        sram_we    = 1'b1;
        sram_be    = be_q;
        sram_wdata = hwdata;
      end
      ST_RD_REQ: begin
        sram_cs   = 1'b1;
        sram_be   = be_q;
        hreadyout = 1'b0;
      end
      ST_RD_DATA: begin
        hrdata = sram_rdata;
        if (par_err) begin
          hreadyout = 1'b0;
          hresp     = HRESP_ERROR;
        end
      end
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
      end
      ST_ERR2: hresp = HRESP_ERROR;
      default: ;
    endcase
  end

`ifdef AHB_SRAM_PARITY_EN
  // Even parity per byte on writes; flag any enabled-lane mismatch on read data.
  always_comb begin
    sram_wpar = '0;
    par_err   = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      sram_wpar[i] = ^sram_wdata[8*i +: 8];
      if (state_q == ST_RD_DATA && be_q[i] && (sram_rpar[i] != ^sram_rdata[8*i +: 8]))
        par_err = 1'b1;
    end
  end
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Self-checking bench: two slave instances (32-bit/0 waits, 64-bit/2 waits)
// share one AHB bus; a behavioural SRAM sits behind each. Expected responses
// are queued when a transfer is accepted and compared when its data phase ends.
module tb_ahb_lite_sram_slave;

  logic        hclk = 1'b0;
  logic        hresetn;
  always #5 hclk = ~hclk;

  logic        hsel_bus;
  logic        sel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic        hwrite;
  logic [63:0] hwdata;

  logic        hsel0, hsel1;
  assign hsel0 = hsel_bus & ~sel;
  assign hsel1 = hsel_bus & sel;

  logic        rdy0, resp0, cs0, we0;
  logic [31:0] rdata0, wd0, srd0;
  logic [3:0]  be0;
  logic [9:0]  a0;

  logic        rdy1, resp1, cs1, we1;
  logic [63:0] rdata1, wd1, srd1;
  logic [7:0]  be1;
  logic [7:0]  a1;

  logic        hready_m, hresp_m;
  logic [63:0] hrdata_m;
  assign hready_m = sel ? rdy1 : rdy0;
  assign hresp_m  = sel ? resp1 : resp0;
  assign hrdata_m = sel ? rdata1 : {32'b0, rdata0};

  ahb_lite_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(0)) u_dut0 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
    .hsize(hsize), .hburst(hburst), .hwrite(hwrite), .hwdata(hwdata[31:0]), .hready(hready_m),
    .hreadyout(rdy0), .hresp(resp0), .hrdata(rdata0), .sram_cs(cs0), .sram_we(we0),
    .sram_be(be0), .sram_addr(a0), .sram_wdata(wd0), .sram_rdata(srd0)
  );

  ahb_lite_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .MEM_DEPTH(256), .WAIT_STATES(2)) u_dut1 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel1), .haddr(haddr), .htrans(htrans),
    .hsize(hsize), .hburst(hburst), .hwrite(hwrite), .hwdata(hwdata), .hready(hready_m),
    .hreadyout(rdy1), .hresp(resp1), .hrdata(rdata1), .sram_cs(cs1), .sram_we(we1),
    .sram_be(be1), .sram_addr(a1), .sram_wdata(wd1), .sram_rdata(srd1)
  );

  // Behavioural synchronous SRAMs with byte enables, plus strobe monitors.
  logic [31:0] mem0 [1024];
  logic [63:0] mem1 [256];
  logic [3:0]  last_be0;
  int          cs0_cnt = 0;

  always @(posedge hclk) begin
    if (cs0) begin
      cs0_cnt <= cs0_cnt + 1;
      if (we0) begin
        for (int b = 0; b < 4; b++) if (be0[b]) mem0[a0][8*b +: 8] <= wd0[8*b +: 8];
        last_be0 <= be0;
      end else begin
        srd0 <= mem0[a0];
      end
    end
    if (cs1) begin
      if (we1) begin
        for (int b = 0; b < 8; b++) if (be1[b]) mem1[a1][8*b +: 8] <= wd1[8*b +: 8];
      end else begin
        srd1 <= mem1[a1];
      end
    end
  end

  typedef struct {
    int          id;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [63:0] wdata;
    logic        chk_rd;
    logic [63:0] exp_rd;
    logic        exp_err;
    int          exp_cyc;
  } xfer_t;

  xfer_t stim[$];
  xfer_t sb[$];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic add_xfer(input int id, input logic wr, input logic [31:0] a, input logic [2:0] sz,
                          input logic [63:0] wd, input logic chk, input logic [63:0] er,
                          input logic err, input int cyc);
    xfer_t t;
    t.id = id; t.wr = wr; t.addr = a; t.size = sz; t.wdata = wd;
    t.chk_rd = chk; t.exp_rd = er; t.exp_err = err; t.exp_cyc = cyc;
    stim.push_back(t);
  endtask

  // Drives queued transfers pipelined on the bus; entered and left at posedge+1.
  task automatic run_seq();
    int   cyc = 0;
    int   guard = 0;
    logic rdy;
    while ((stim.size() > 0 || sb.size() > 0) && guard < 100) begin
      guard++;
      hwdata = (sb.size() > 0) ? sb[0].wdata : 64'd0;
      if (stim.size() > 0) begin
        hsel_bus = 1'b1; haddr = stim[0].addr; htrans = 2'b10;
        hsize = stim[0].size; hwrite = stim[0].wr; hburst = 3'd0;
      end else begin
        hsel_bus = 1'b0; htrans = 2'b00;
      end
      @(negedge hclk);
      rdy = hready_m;
      if (sb.size() > 0) begin
        cyc++;
        if (!rdy) check($sformatf("x%0d_wait_hresp", sb[0].id), 64'(hresp_m), 64'(sb[0].exp_err));
        if (rdy) begin
          check($sformatf("x%0d_cycles", sb[0].id), 64'(cyc), 64'(sb[0].exp_cyc));
          check($sformatf("x%0d_hresp", sb[0].id), 64'(hresp_m), 64'(sb[0].exp_err));
          if (sb[0].chk_rd) check($sformatf("x%0d_rdata", sb[0].id), hrdata_m, sb[0].exp_rd);
          void'(sb.pop_front());
          cyc = 0;
        end
      end
      @(posedge hclk); #1;
      if (rdy && stim.size() > 0) sb.push_back(stim.pop_front());
    end
    hsel_bus = 1'b0; htrans = 2'b00;
    check("seq_drain", 64'(stim.size() + sb.size()), 64'd0);
  endtask

  int         cs_save;
  logic [1:0] idle_tr [2];

  initial begin
    hresetn = 1'b0; hsel_bus = 1'b0; sel = 1'b0; haddr = '0; htrans = 2'b00;
    hsize = 3'd0; hburst = 3'd0; hwrite = 1'b0; hwdata = '0;
    idle_tr[0] = 2'b00; idle_tr[1] = 2'b01;

    repeat (2) @(posedge hclk);
    #1;
    check("rst_hreadyout0", 64'(rdy0), 64'd1);
    check("rst_hresp0", 64'(resp0), 64'd0);
    check("rst_hrdata0", 64'(rdata0), 64'd0);
    check("rst_cs0", 64'(cs0), 64'd0);
    check("rst_we0", 64'(we0), 64'd0);
    check("rst_be0", 64'(be0), 64'd0);
    check("rst_hreadyout1", 64'(rdy1), 64'd1);
    check("rst_cs1", 64'(cs1), 64'd0);
    @(negedge hclk) hresetn = 1'b1;
    @(posedge hclk); #1;

    // 32-bit, no waits: word write then read back to back.
    sel = 1'b0;
    add_xfer(1, 1, 32'h10, 3'd2, 64'hDEADBEEF, 0, 0, 0, 1);
    add_xfer(2, 0, 32'h10, 3'd2, 64'd0, 1, 64'hDEADBEEF, 0, 2);
    run_seq();

    // Byte write into lane 3 over an existing word.
    add_xfer(3, 1, 32'h10, 3'd2, 64'h11223344, 0, 0, 0, 1);
    add_xfer(4, 1, 32'h13, 3'd0, 64'hAA000000, 0, 0, 0, 1);
    run_seq();
    check("byte_be", 64'(last_be0), 64'h8);
    add_xfer(5, 0, 32'h10, 3'd2, 64'd0, 1, 64'hAA223344, 0, 2);
    run_seq();

    // Out-of-range read: two-cycle ERROR, SRAM untouched.
    cs_save = cs0_cnt;
    add_xfer(6, 0, 32'h1000, 3'd2, 64'd0, 0, 0, 1, 2);
    run_seq();
    check("range_no_cs", 64'(cs0_cnt), 64'(cs_save));

    // Misaligned halfword; the following NONSEQ is taken during ERR2.
    add_xfer(7, 0, 32'h01, 3'd1, 64'd0, 0, 0, 1, 2);
    add_xfer(8, 0, 32'h10, 3'd2, 64'd0, 1, 64'hAA223344, 0, 2);
    run_seq();

    // Oversize transfer on a 32-bit bus.
    cs_save = cs0_cnt;
    add_xfer(9, 1, 32'h10, 3'd3, 64'h0, 0, 0, 1, 2);
    run_seq();
    check("size_no_cs", 64'(cs0_cnt), 64'(cs_save));

    // Last word of the memory, including an upper-halfword write.
    add_xfer(10, 1, 32'hFFC, 3'd2, 64'h5A5AC3C3, 0, 0, 0, 1);
    add_xfer(11, 0, 32'hFFC, 3'd2, 64'd0, 1, 64'h5A5AC3C3, 0, 2);
    add_xfer(12, 1, 32'hFFE, 3'd1, 64'hBEEF0000, 0, 0, 0, 1);
    add_xfer(13, 0, 32'hFFC, 3'd2, 64'd0, 1, 64'hBEEFC3C3, 0, 2);
    run_seq();

    // IDLE and BUSY with hsel high: ready, OKAY, no SRAM activity.
    cs_save = cs0_cnt;
    foreach (idle_tr[k]) begin
      hsel_bus = 1'b1; haddr = 32'h10; htrans = idle_tr[k]; hsize = 3'd2; hwrite = 1'b0;
      repeat (2) @(negedge hclk);
      check($sformatf("idle%0d_hreadyout", k), 64'(hready_m), 64'd1);
      check($sformatf("idle%0d_hresp", k), 64'(hresp_m), 64'd0);
      @(posedge hclk); #1;
    end
    hsel_bus = 1'b0; htrans = 2'b00;
    check("idle_no_cs", 64'(cs0_cnt), 64'(cs_save));

    // 64-bit, two wait states: chained write/read, lane write, range limit.
    sel = 1'b1;
    add_xfer(20, 1, 32'h20, 3'd3, 64'h0123456789ABCDEF, 0, 0, 0, 3);
    add_xfer(21, 0, 32'h20, 3'd3, 64'd0, 1, 64'h0123456789ABCDEF, 0, 4);
    add_xfer(22, 1, 32'h24, 3'd2, 64'hCAFEF00D_00000000, 0, 0, 0, 3);
    add_xfer(23, 0, 32'h20, 3'd3, 64'd0, 1, 64'hCAFEF00D89ABCDEF, 0, 4);
    add_xfer(24, 0, 32'h800, 3'd3, 64'd0, 0, 0, 1, 2);
    run_seq();

    // Asynchronous reset while a read sits in RD_REQ.
    sel = 1'b0;
    hsel_bus = 1'b1; haddr = 32'h10; htrans = 2'b10; hsize = 3'd2; hwrite = 1'b0;
    @(posedge hclk); #1;
    hsel_bus = 1'b0; htrans = 2'b00;
    @(negedge hclk);
    check("rdreq_hreadyout", 64'(hready_m), 64'd0);
    check("rdreq_cs", 64'(cs0), 64'd1);
    hresetn = 1'b0;
    #1;
    check("midrst_hreadyout", 64'(rdy0), 64'd1);
    check("midrst_hresp", 64'(resp0), 64'd0);
    check("midrst_cs", 64'(cs0), 64'd0);
    @(negedge hclk) hresetn = 1'b1;
    @(posedge hclk); #1;
    add_xfer(30, 0, 32'h10, 3'd2, 64'd0, 1, 64'hAA223344, 0, 2);
    run_seq();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ahb_lite_sram_slave.md
Name: ahb_lite_sram_slave

Overview:
Parametrised AHB-Lite slave that bridges the AHB bus to a single-port synchronous SRAM macro. It generalises the fixed 32-bit RAM target to configurable data width, memory depth and wait states. It adds byte-lane writes, range and alignment checking with the two-cycle ERROR response, and an optional parity check. It sits behind the AHB decoder, driven by hsel, and is the DUT the lvc_ahb VIP agents stimulate.

Parameters:
- ADDR_WIDTH, 32, width of haddr.
- DATA_WIDTH, 32, width of hwdata/hrdata; legal values are 32 or 64.
- MEM_DEPTH, 1024, number of DATA_WIDTH words in the SRAM; must be a power of two.
- WAIT_STATES, 0, extra data-phase wait cycles added to every OKAY read and write; range 0..3.

Ports:
- hclk  in  1  clock
- hresetn  in  1  asynchronous reset, active-low
- hsel  in  1  slave select from the decoder
- haddr  in  ADDR_WIDTH  address
- htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- hsize  in  3  transfer size, 2^hsize bytes
- hburst  in  3  burst type; accepted but only used for debug
- hwrite  in  1  1=write
- hwdata  in  DATA_WIDTH  write data, valid in the data phase
- hready  in  1  bus-level ready; qualifies address-phase sampling
- hreadyout  out  1  slave ready
- hresp  out  1  0=OKAY, 1=ERROR
- hrdata  out  DATA_WIDTH  read data
- sram_cs  out  1  SRAM chip select
- sram_we  out  1  SRAM write enable
- sram_be  out  DATA_WIDTH/8  SRAM byte enables
- sram_addr  out  log2(MEM_DEPTH)  SRAM word address
- sram_wdata  out  DATA_WIDTH  SRAM write data
- sram_rdata  in  DATA_WIDTH  SRAM read data, valid the cycle after sram_cs with sram_we=0

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - state=IDLE; hreadyout=1, hresp=0, hrdata=0, sram_cs=0, sram_we=0, sram_be=0.
  - Any pending access is dropped.
- Address-phase accept condition: hsel & hready & htrans[1]. On accept, register haddr, hsize and hwrite.
  - IDLE or BUSY with hsel=1 gives a zero-wait OKAY.
  - hsel=0 leaves the slave idle.
- Error check, performed at accept:
  - Error cases: haddr >= MEM_DEPTH*(DATA_WIDTH/8); 2^hsize > DATA_WIDTH/8; haddr not aligned to 2^hsize.
  - Response: ERR1 (hreadyout=0, hresp=1), then ERR2 (hreadyout=1, hresp=1).
  - No SRAM access occurs.
  - A new transfer presented during ERR2 is accepted normally.
- State machine: IDLE, WAIT, WR, RD_REQ, RD_DATA, ERR1, ERR2.
  - Accepted OKAY transfer: go to WAIT if WAIT_STATES>0, otherwise to WR or RD_REQ.
  - WAIT: hreadyout=0 for WAIT_STATES cycles, then WR or RD_REQ.
  - WR: sram_cs=1, sram_we=1, sram_wdata=hwdata, sram_be from the byte-lane decode, hreadyout=1. Writes therefore complete with zero extra waits when WAIT_STATES=0.
  - RD_REQ: sram_cs=1, sram_we=0, hreadyout=0.
  - RD_DATA: hrdata=sram_rdata (registered), hreadyout=1. Minimum read data phase is 2 cycles.
  - In WR and RD_DATA (hreadyout=1), a newly accepted transfer chains directly (pipelined back-to-back); otherwise the FSM returns to IDLE.
- Byte lanes (little-endian):
  - byte enable bit i = 1 for i in [addr_lo, addr_lo + 2^hsize − 1], where addr_lo = haddr[log2(DATA_WIDTH/8)−1:0].
  - sram_addr = haddr >> log2(DATA_WIDTH/8).
  - hrdata returns the full word; the master selects lanes.
- Outside the states above, hrdata holds its last value and sram_* are deasserted.
- Read-after-write to the same address: the write completes in WR before RD_REQ issues, so the read returns the new data. No forwarding is needed.

Optional Feature:
- Macro: AHB_SRAM_PARITY_EN.
- Defined:
  - Extra ports sram_wpar out DATA_WIDTH/8 and sram_rpar in DATA_WIDTH/8 carry even parity per byte.
  - On a read, any enabled-lane mismatch in RD_DATA converts the response to ERR1/ERR2; hrdata is still driven.
- Undefined: no parity ports and no parity check.

Decomposition:
- ahb_sram_pkg holds:
  - htrans_e and hsize_e enums;
  - the sram_state_e FSM enum;
  - HRESP_OKAY/HRESP_ERROR constants;
  - function calc_be(addr_lo, hsize).
- Sub-module ahb_sram_addr_chk does combinational range/size/alignment check plus byte-enable and word-address decode.

Test Plan:
- DATA_WIDTH=32, WAIT_STATES=0: write 0xDEADBEEF to 0x10, then read 0x10 -> write has 0 waits; read has 1 wait cycle and hrdata=0xDEADBEEF, hresp=0.
- Byte write 0xAA, hsize=0, to 0x13 after word 0x11223344 at 0x10 -> sram_be=4'b1000; readback 0xAA223344.
- Read at 0x1000 with MEM_DEPTH=1024 -> ERR1 then ERR2 (hreadyout 0 then 1, hresp=1 both cycles); sram_cs never asserted.
- Halfword at 0x01 -> alignment ERROR; a NONSEQ presented during ERR2 completes OKAY.
- WAIT_STATES=2, DATA_WIDTH=64: back-to-back NONSEQ write then read -> write data phase 3 cycles, read 4 cycles, correct 64-bit data.
- Deassert hresetn while in RD_REQ -> hreadyout=1, hresp=0, sram_cs=0 immediately; a subsequent read completes normally.
